reg_table_access: RTL and testbench

//  Host-side access controller for the switch register table.

---
 rtl/reg_table_access.sv | 104 ++++++++++
 tb/tb_reg_table_access.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/reg_table_access.sv
// Host-side access controller for the switch register table: one req/ack transaction
// at a time, decoded into one-hot write strobes and a read-back mux over packed register outputs.
module reg_table_access #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      host_req,
    input  logic                      host_we,
    input  logic [ADDR_W-1:0]         host_addr,
    input  logic [WIDTH-1:0]          host_wdata,
    output logic                      host_ack,
    output logic                      host_err,
    output logic [WIDTH-1:0]          host_rdata,
    output logic                      host_busy,
    output logic [NUM_REGS-1:0]       reg_wr,
    output logic [WIDTH-1:0]          reg_din,
    input  logic [NUM_REGS*WIDTH-1:0] reg_dout
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP,
        WAIT_REL
    } state_t;

    // One extra bit so NUM_REGS == 2**ADDR_W compares correctly and never flags an error.
    localparam logic [ADDR_W:0] NUM_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    state_t              state;
    state_t              state_next;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WIDTH-1:0]    wdata_q;
    logic                addr_ok;
    logic [WIDTH-1:0]    read_slice;

    assign addr_ok = ({1'b0, addr_q} < NUM_LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (host_req) state_next = EXEC;
            EXEC:     state_next = RESP;
            RESP:     state_next = WAIT_REL;
            WAIT_REL: if (!host_req) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Request fields are captured only in IDLE, so later changes on the bus are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && host_req) begin
            we_q    <= host_we;
            addr_q  <= host_addr;
            wdata_q <= host_wdata;
        end
    end

    always_comb begin
        read_slice = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) read_slice = reg_dout[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_rdata <= '0;
        end else if (state == EXEC) begin
            host_rdata <= (!we_q && addr_ok) ? read_slice : '0;
        end
    end

    always_comb begin
        reg_wr = '0;
        if (state == EXEC && we_q && addr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_wr[i] = (addr_q == ADDR_W'(i));
            end
        end
    end

    assign reg_din   = wdata_q;
    assign host_ack  = (state == RESP);
    assign host_err  = (state == RESP) && !addr_ok;
    assign host_busy = (state != IDLE);

endmodule

// File: tb/tb_reg_table_access.sv
// Directed bench for reg_table_access: an 8-register instance backed by a register model
// and a 6-register instance with fixed read patterns, both sharing the host bus.
module tb_reg_table_access;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [2:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;

    logic        ack8, err8, busy8, ack6, err6, busy6;
    logic [15:0] rdata8, din8, rdata6, din6;
    logic [7:0]  reg_wr8;
    logic [5:0]  reg_wr6;
    logic [127:0] reg_dout8;
    logic [95:0]  reg_dout6;
    logic [15:0] regs8 [8] = '{default: '0};

    int total = 0;
    int bad = 0;

    int pulses8, pulses6, acks8, acks6, strobe_cyc8, ack_cyc8, busy_hi, stray_err;
    logic [7:0]  cap_wr8;
    logic [5:0]  cap_wr6;
    logic [15:0] cap_din8, cap_rdata8, cap_rdata6;
    logic        cap_err8, cap_err6, released;

    always #5 clk = ~clk;

    reg_table_access #(.WIDTH(16), .NUM_REGS(8), .ADDR_W(3)) dut8 (
        .clk(clk), .reset(reset), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(ack8),
        .host_err(err8), .host_rdata(rdata8), .host_busy(busy8),
        .reg_wr(reg_wr8), .reg_din(din8), .reg_dout(reg_dout8)
    );

    reg_table_access #(.WIDTH(16), .NUM_REGS(6), .ADDR_W(3)) dut6 (
        .clk(clk), .reset(reset), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(ack6),
        .host_err(err6), .host_rdata(rdata6), .host_busy(busy6),
        .reg_wr(reg_wr6), .reg_din(din6), .reg_dout(reg_dout6)
    );

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) if (reg_wr8[i]) regs8[i] <= din8;
    end

    always_comb begin
        reg_dout8 = '0;
        for (int i = 0; i < 8; i++) reg_dout8[i*16 +: 16] = regs8[i];
    end

    assign reg_dout6 = {16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001, 16'hA000};

    task automatic clear_obs();
        pulses8 = 0; pulses6 = 0; acks8 = 0; acks6 = 0; strobe_cyc8 = -1; ack_cyc8 = -1;
        busy_hi = 0; stray_err = 0; cap_wr8 = '0; cap_wr6 = '0; cap_din8 = '0;
        cap_rdata8 = '0; cap_rdata6 = '0; cap_err8 = 1'b0; cap_err6 = 1'b0; released = 1'b0;
    endtask

    task automatic observe(input int cyc);
        if (reg_wr8 != 0) begin pulses8++; cap_wr8 = reg_wr8; cap_din8 = din8; strobe_cyc8 = cyc; end
        if (reg_wr6 != 0) begin pulses6++; cap_wr6 = reg_wr6; end
        if (ack8) begin acks8++; cap_err8 = err8; cap_rdata8 = rdata8; ack_cyc8 = cyc; end
        if (ack6) begin acks6++; cap_err6 = err6; cap_rdata6 = rdata6; end
        if ((!ack8 && err8) || (!ack6 && err6)) stray_err++;
        if (busy8) busy_hi++;
    endtask

    // Drives one transaction holding req for 'hold' cycles after the sampling edge.
    task automatic run_txn(input logic we, input logic [2:0] addr, input logic [15:0] wdata,
                           input int hold, input logic scramble);
        clear_obs();
        @(negedge clk);
        host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
        for (int c = 1; c <= hold; c++) begin
            @(negedge clk);
            observe(c);
            if (scramble && c == 1) begin
                host_we = ~we; host_addr = addr ^ 3'b111; host_wdata = ~wdata;
            end
        end
        host_req = 1'b0;
        for (int c = hold + 1; c <= hold + 8; c++) begin
            @(negedge clk);
            observe(c);
            if (!busy8 && !busy6) begin released = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (ack8 !== 1'b0) begin bad++; $display("[TB] FAIL rst_ack: got %b want 0", ack8); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b want 0", busy8); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if ({ack8, err8, busy8} !== 3'b000) begin bad++; $display("[TB] FAIL rel_flags: got %b want 000", {ack8, err8, busy8}); end
        total++; if (rdata8 !== 16'h0) begin bad++; $display("[TB] FAIL rel_rdata: got %h want 0000", rdata8); end
        total++; if (reg_wr8 !== 8'h0) begin bad++; $display("[TB] FAIL rel_wr: got %b want 0", reg_wr8); end
        total++; if (din8 !== 16'h0) begin bad++; $display("[TB] FAIL rel_din: got %h want 0000", din8); end
        total++; if ({ack6, err6, busy6, reg_wr6} !== 9'h0) begin bad++; $display("[TB] FAIL rel_dut6: got %h want 0", {ack6, err6, busy6, reg_wr6}); end
    endtask

    task automatic test_write();
        run_txn(1'b1, 3'd2, 16'hBEEF, 3, 1'b0);
        total++; if (pulses8 !== 1) begin bad++; $display("[TB] FAIL wr_pulses: got %0d want 1", pulses8); end
        total++; if (cap_wr8 !== 8'b0000_0100) begin bad++; $display("[TB] FAIL wr_strobe: got %b want 00000100", cap_wr8); end
        total++; if (cap_din8 !== 16'hBEEF) begin bad++; $display("[TB] FAIL wr_din: got %h want beef", cap_din8); end
        total++; if (strobe_cyc8 !== 1) begin bad++; $display("[TB] FAIL wr_strobe_lat: got %0d want 1", strobe_cyc8); end
        total++; if (ack_cyc8 !== 2) begin bad++; $display("[TB] FAIL wr_ack_lat: got %0d want 2", ack_cyc8); end
        total++; if (acks8 !== 1 || cap_err8 !== 1'b0) begin bad++; $display("[TB] FAIL wr_ack: got acks=%0d err=%b want 1/0", acks8, cap_err8); end
        total++; if (cap_wr6 !== 6'b000100) begin bad++; $display("[TB] FAIL wr6_strobe: got %b want 000100", cap_wr6); end
        total++; if (released !== 1'b1) begin bad++; $display("[TB] FAIL wr_release: got %b want 1", released); end
        total++; if (regs8[2] !== 16'hBEEF) begin bad++; $display("[TB] FAIL wr_reg2: got %h want beef", regs8[2]); end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 3'd5, 16'h1234, 3, 1'b0);
        run_txn(1'b0, 3'd5, 16'h0000, 3, 1'b0);
        total++; if (cap_rdata8 !== 16'h1234) begin bad++; $display("[TB] FAIL b2b_rdata: got %h want 1234", cap_rdata8); end
        total++; if (acks8 !== 1 || cap_err8 !== 1'b0) begin bad++; $display("[TB] FAIL b2b_ack: got acks=%0d err=%b want 1/0", acks8, cap_err8); end
        total++; if (pulses8 !== 0) begin bad++; $display("[TB] FAIL b2b_rd_pulses: got %0d want 0", pulses8); end
        total++; if (cap_rdata6 !== 16'hA005 || cap_err6 !== 1'b0) begin bad++; $display("[TB] FAIL b2b_last_valid: got %h/%b want a005/0", cap_rdata6, cap_err6); end
        total++; if (rdata8 !== 16'h1234) begin bad++; $display("[TB] FAIL b2b_hold: got %h want 1234", rdata8); end
    endtask

    task automatic test_out_of_range();
        run_txn(1'b1, 3'd7, 16'h5555, 3, 1'b0);
        total++; if (pulses6 !== 0) begin bad++; $display("[TB] FAIL oor_pulses: got %0d want 0", pulses6); end
        total++; if (acks6 !== 1 || cap_err6 !== 1'b1) begin bad++; $display("[TB] FAIL oor_err: got acks=%0d err=%b want 1/1", acks6, cap_err6); end
        total++; if (cap_rdata6 !== 16'h0) begin bad++; $display("[TB] FAIL oor_rdata: got %h want 0000", cap_rdata6); end
        total++; if (cap_wr8 !== 8'h80 || cap_err8 !== 1'b0) begin bad++; $display("[TB] FAIL full_range_wr: got %b/%b want 10000000/0", cap_wr8, cap_err8); end
        total++; if (cap_rdata8 !== 16'h0) begin bad++; $display("[TB] FAIL wr_resp_rdata: got %h want 0000", cap_rdata8); end
        run_txn(1'b0, 3'd6, 16'h0000, 3, 1'b0);
        total++; if (cap_err6 !== 1'b1 || cap_rdata6 !== 16'h0) begin bad++; $display("[TB] FAIL oor_first: got err=%b rdata=%h want 1/0000", cap_err6, cap_rdata6); end
        run_txn(1'b0, 3'd7, 16'h0000, 3, 1'b0);
        total++; if (cap_rdata8 !== 16'h5555 || cap_err8 !== 1'b0) begin bad++; $display("[TB] FAIL full_range_rd: got %h/%b want 5555/0", cap_rdata8, cap_err8); end
        total++; if (stray_err !== 0) begin bad++; $display("[TB] FAIL err_no_ack: got %0d want 0", stray_err); end
    endtask

    task automatic test_held_req();
        run_txn(1'b1, 3'd1, 16'h0F0F, 10, 1'b1);
        total++; if (pulses8 !== 1 || cap_wr8 !== 8'b0000_0010) begin bad++; $display("[TB] FAIL held_pulse: got n=%0d wr=%b want 1/00000010", pulses8, cap_wr8); end
        total++; if (cap_din8 !== 16'h0F0F) begin bad++; $display("[TB] FAIL held_din: got %h want 0f0f", cap_din8); end
        total++; if (acks8 !== 1) begin bad++; $display("[TB] FAIL held_acks: got %0d want 1", acks8); end
        total++; if (busy_hi !== 10) begin bad++; $display("[TB] FAIL held_busy: got %0d want 10", busy_hi); end
        total++; if (released !== 1'b1) begin bad++; $display("[TB] FAIL held_release: got %b want 1", released); end
        total++; if (regs8[1] !== 16'h0F0F || regs8[6] !== 16'h0) begin bad++; $display("[TB] FAIL held_regs: got %h/%h want 0f0f/0000", regs8[1], regs8[6]); end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = 3'd3; host_wdata = 16'hDEAD;
        @(negedge clk);
        total++; if (reg_wr8 !== 8'b0000_1000) begin bad++; $display("[TB] FAIL mid_exec_wr: got %b want 00001000", reg_wr8); end
        #2 reset = 1'b0;
        #1;
        total++; if (reg_wr8 !== 8'h0 || busy8 !== 1'b0) begin bad++; $display("[TB] FAIL mid_drop: got wr=%b busy=%b want 0/0", reg_wr8, busy8); end
        host_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin @(negedge clk); observe(c); end
        total++; if (acks8 !== 0 || pulses8 !== 0) begin bad++; $display("[TB] FAIL mid_no_ack: got acks=%0d pulses=%0d want 0/0", acks8, pulses8); end
        reset = 1'b1;
        run_txn(1'b0, 3'd3, 16'h0000, 3, 1'b0);
        total++; if (acks8 !== 1 || cap_rdata8 !== 16'h0) begin bad++; $display("[TB] FAIL mid_after_rd: got acks=%0d rdata=%h want 1/0000", acks8, cap_rdata8); end
    endtask

    task automatic test_read_all();
        logic [15:0] pat [8];
        pat = '{16'h3C00, 16'h3D11, 16'h3E22, 16'h3F33, 16'h4044, 16'h4155, 16'h4266, 16'h4377};
        for (int i = 0; i < 8; i++) run_txn(1'b1, 3'(i), pat[i], 3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_txn(1'b0, 3'(i), 16'hFFFF, 3, 1'b0);
            total++; if (cap_rdata8 !== pat[i] || cap_err8 !== 1'b0) begin bad++; $display("[TB] FAIL rd_all8[%0d]: got %h/%b want %h/0", i, cap_rdata8, cap_err8, pat[i]); end
            total++; if (pulses8 !== 0 || pulses6 !== 0) begin bad++; $display("[TB] FAIL rd_all_pulses[%0d]: got %0d/%0d want 0/0", i, pulses8, pulses6); end
            if (i < 6) begin
                total++; if (cap_rdata6 !== (16'hA000 + 16'(i)) || cap_err6 !== 1'b0) begin bad++; $display("[TB] FAIL rd_all6[%0d]: got %h/%b want %h/0", i, cap_rdata6, cap_err6, 16'hA000 + 16'(i)); end
            end else begin
                total++; if (cap_rdata6 !== 16'h0 || cap_err6 !== 1'b1) begin bad++; $display("[TB] FAIL rd_all6_err[%0d]: got %h/%b want 0000/1", i, cap_rdata6, cap_err6); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_out_of_range();
        test_held_req();
        test_reset_mid();
        test_read_all();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
